checksum_fold_scheduler: RTL and testbench

//  Shared IPv4 header-checksum fold/finalise engine for the output-port-lookup pipeline.
//  Up to N_REQ pipeline stages submit {32-bit partial sum, 16-bit addend} requests.

---
 rtl/checksum_fold_scheduler_pkg.sv | 23 ++
 rtl/checksum_rr_arbiter.sv | 52 +++++
 rtl/checksum_fold_scheduler.sv | 155 +++++++++++++++
 tb/tb_checksum_fold_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_fold_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// checksum_fold_scheduler_pkg
// Shared definitions for the checksum fold/finalise engine:
//   - FSM state encodings (IDLE, FOLD1, FOLD2, OUT)
//   - CSUM_OK: folded value of a header that verifies
//   - fold16(): one 16-bit end-around-carry fold step on the 34-bit accumulator
// ----------------------------------------------------------------------------
package checksum_fold_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FOLD1 = 2'd1;
    localparam logic [1:0] ST_FOLD2 = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [15:0] CSUM_OK = 16'hFFFF;

    // Adds the upper 18 bits back onto the low 16. Two applications always
    // suffice for any 32-bit sum plus 16-bit addend.
    function automatic logic [33:0] fold16(input logic [33:0] x);
        return {18'd0, x[15:0]} + {16'd0, x[33:16]};
    endfunction

endpackage

// File: rtl/checksum_rr_arbiter.sv
// ----------------------------------------------------------------------------
// checksum_rr_arbiter
// Purely combinational round-robin arbiter. The winner is the first candidate
// (request & mask) found searching from i_rr_ptr upward, wrapping at N_REQ.
// The pointer itself is held by the caller.
// Ports:
//   i_req    N_REQ  request vector
//   i_mask   N_REQ  1 = requester enabled
//   i_rr_ptr ID_W   search start index (must be < N_REQ)
//   i_en     1      arbitration enabled; when 0 no grant is issued
//   o_grant  N_REQ  one-hot grant (all-zero when no winner)
//   o_idx    ID_W   encoded winner index (0 when no winner)
//   o_any    1      a winner exists
// ----------------------------------------------------------------------------
module checksum_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_mask,
    input  logic [ID_W-1:0]  i_rr_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [N_REQ-1:0] w_cand;
    logic [ID_W:0]    w_pos;

    assign w_cand = i_req & i_mask & {N_REQ{i_en}};

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit holds rr_ptr + k before the modulo wrap.
            w_pos = {1'b0, i_rr_ptr} + (ID_W+1)'(k);
            if (w_pos >= (ID_W+1)'(N_REQ)) begin
                w_pos = w_pos - (ID_W+1)'(N_REQ);
            end
            if (!o_any && w_cand[w_pos[ID_W-1:0]]) begin
                o_any                   = 1'b1;
                o_idx                   = w_pos[ID_W-1:0];
                o_grant[w_pos[ID_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/checksum_fold_scheduler.sv
// ----------------------------------------------------------------------------
// checksum_fold_scheduler
// Shared IPv4 header-checksum fold/finalise engine. Requesters submit a 32-bit
// partial sum plus a 16-bit addend; one is granted round-robin, folded twice to
// 16 bits with end-around carry, and returned complemented with a verify flag
// and the owning requester ID. Latency accept -> res_valid is 3 cycles.
// Ports:
//   AXI_ACLK     in   clock, rising edge
//   AXI_RESET    in   synchronous active-high reset
//   req_valid    in   N_REQ      per-requester valid
//   req_ready    out  N_REQ      one-hot grant
//   req_sum      in   N_REQ*32   partial sums, requester i at [32*i +: 32]
//   req_addend   in   N_REQ*16   addends, requester i at [16*i +: 16]
//   req_mask     in   N_REQ      1 = requester may be granted
//   res_valid    out  result valid
//   res_ready    in   result consumer ready
//   res_id       out  ID_W       requester owning the result
//   res_csum     out  16         complemented folded sum
//   res_ok       out  folded sum == 16'hFFFF
//   busy         out  engine not idle
//   grant_count  out  CNT_W      accepted requests, saturating
// ----------------------------------------------------------------------------
module checksum_fold_scheduler
    import checksum_fold_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 32
) (
    input  logic                AXI_ACLK,
    input  logic                AXI_RESET,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_sum,
    input  logic [N_REQ*16-1:0] req_addend,
    input  logic [N_REQ-1:0]    req_mask,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ID_W-1:0]     res_id,
    output logic [15:0]         res_csum,
    output logic                res_ok,
    output logic                busy,
    output logic [CNT_W-1:0]    grant_count
);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_id;
    logic [33:0]      r_acc;
    logic             r_res_valid;
    logic [15:0]      r_res_csum;
    logic             r_res_ok;
    logic [ID_W-1:0]  r_res_id;
    logic [CNT_W-1:0] r_cnt;

    logic             w_arb_en;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_accept;
    logic [31:0]      w_sel_sum;
    logic [15:0]      w_sel_add;
    logic [33:0]      w_load;
    logic [33:0]      w_fold;
    logic [ID_W-1:0]  w_rr_next;

    // A new request can be taken while idle, or in OUT on the same edge the
    // current result is consumed, giving back-to-back accepts every 3 cycles.
    assign w_arb_en = (r_state == ST_IDLE) || ((r_state == ST_OUT) && res_ready);

    checksum_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req    (req_valid),
        .i_mask   (req_mask),
        .i_rr_ptr (r_rr_ptr),
        .i_en     (w_arb_en),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_accept)
    );

    // Operands are taken only from the granted requester.
    always_comb begin
        w_sel_sum = '0;
        w_sel_add = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_sum = req_sum[32*i +: 32];
                w_sel_add = req_addend[16*i +: 16];
            end
        end
    end

    assign w_load    = {2'b00, w_sel_sum} + {18'd0, w_sel_add};
    assign w_fold    = fold16(r_acc);
    assign w_rr_next = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
            r_res_csum  <= '0;
            r_res_ok    <= 1'b0;
            r_res_id    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= ST_FOLD1;
                end
                ST_FOLD1: begin
                    r_acc   <= w_fold;
                    r_state <= ST_FOLD2;
                end
                ST_FOLD2: begin
                    // Second fold lands directly in the result registers.
                    r_acc       <= w_fold;
                    r_state     <= ST_OUT;
                    r_res_valid <= 1'b1;
                    r_res_csum  <= ~w_fold[15:0];
                    r_res_ok    <= (w_fold[15:0] == CSUM_OK);
                    r_res_id    <= r_id;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_accept ? ST_FOLD1 : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // w_accept is only possible in IDLE or OUT, never alongside a fold.
            if (w_accept) begin
                r_acc    <= w_load;
                r_id     <= w_idx;
                r_rr_ptr <= w_rr_next;
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req_ready   = w_grant;
    assign res_valid   = r_res_valid;
    assign res_csum    = r_res_csum;
    assign res_ok      = r_res_ok;
    assign res_id      = r_res_id;
    assign busy        = (r_state != ST_IDLE);
    assign grant_count = r_cnt;

endmodule

// File: tb/tb_checksum_fold_scheduler.sv
module tb_checksum_fold_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_sum;
    logic [N*16-1:0]  req_addend;
    logic [N-1:0]     req_mask;
    logic             res_valid;
    logic             res_ready;
    logic [IDW-1:0]   res_id;
    logic [15:0]      res_csum;
    logic             res_ok;
    logic             busy;
    logic [CW-1:0]    grant_count;

    always #5 clk = ~clk;

    checksum_fold_scheduler #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
        .AXI_ACLK    (clk),
        .AXI_RESET   (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sum     (req_sum),
        .req_addend  (req_addend),
        .req_mask    (req_mask),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_csum    (res_csum),
        .res_ok      (res_ok),
        .busy        (busy),
        .grant_count (grant_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [15:0] csum;
        logic        ok;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    int     glog_id[$];
    longint glog_cyc[$];
    longint cyc     = 0;
    bit     started = 0;
    bit     in_rst  = 0;
    int     m_rr    = 0;
    longint m_cnt   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference checksum: add, then fold carries back in until none remain.
    function automatic logic [15:0] ref_fold(input logic [31:0] s, input logic [15:0] a);
        longint t;
        t = longint'(s) + longint'(a);
        while (t > 64'hFFFF) t = (t & 64'hFFFF) + (t >> 16);
        return t[15:0];
    endfunction

    always @(posedge clk) begin
        cyc++;
        in_rst  = rst;
        started = 1;
    end

    // Monitor / scoreboard
    logic [N-1:0] m_cand, m_eg;
    bit           m_vld, m_can;
    int           m_w;
    exp_t         m_e;
    logic [15:0]  m_f;

    always @(negedge clk) begin
        if (started) begin
            if (in_rst) begin
                chk("rst_res_valid", res_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_grant_count", grant_count, 0);
                chk("rst_res_csum", res_csum, 0);
                chk("rst_res_id", res_id, 0);
                chk("rst_res_ok", res_ok, 0);
                sb.delete();
                m_rr  = 0;
                m_cnt = 0;
            end
            m_vld = (sb.size() != 0) && (cyc >= sb[0].cyc + 3);
            chk("busy", busy, sb.size() != 0);
            chk("res_valid", res_valid, m_vld);
            if (m_vld) begin
                chk("res_id", res_id, sb[0].id);
                chk("res_csum", res_csum, sb[0].csum);
                chk("res_ok", res_ok, sb[0].ok);
            end
            chk("grant_count", grant_count, m_cnt);
            m_can  = (sb.size() == 0) || (m_vld && res_ready);
            m_cand = req_valid & req_mask;
            m_eg   = '0;
            m_w    = -1;
            if (m_can) begin
                for (int k = 0; k < N; k++) begin
                    if (m_w < 0 && m_cand[(m_rr + k) % N]) m_w = (m_rr + k) % N;
                end
            end
            if (m_w >= 0) m_eg[m_w] = 1'b1;
            chk("req_ready", req_ready, m_eg);
            if (m_vld && res_ready) void'(sb.pop_front());
            if (m_w >= 0 && !rst) begin
                m_f      = ref_fold(req_sum[32*m_w +: 32], req_addend[16*m_w +: 16]);
                m_e.id   = m_w;
                m_e.csum = ~m_f;
                m_e.ok   = (m_f == 16'hFFFF);
                m_e.cyc  = cyc;
                sb.push_back(m_e);
                glog_id.push_back(m_w);
                glog_cyc.push_back(cyc);
                m_rr = (m_w + 1) % N;
                m_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            req_sum[32*i +: 32]    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            req_addend[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 50 && busy; i++) step();
        chk("drain_timeout", busy, 0);
    endtask

    task automatic wait_log(input int n, input string nm);
        for (int i = 0; i < 60 && glog_id.size() < n; i++) step();
        chk(nm, glog_id.size() >= n, 1);
    endtask

    task automatic wait_res(input string nm);
        for (int i = 0; i < 20 && !res_valid; i++) step();
        chk(nm, res_valid, 1);
    endtask

    longint      c0;
    logic [15:0] h_csum;
    logic [IDW-1:0] h_id;
    logic        h_ok;
    logic [CW-1:0] h_cnt;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_mask   = '1;
        res_ready  = 1'b1;
        req_sum    = '0;
        req_addend = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Test 1: requester 0, no carry
        randomize_data();
        req_sum[31:0]    = 32'h0001_2345;
        req_addend[15:0] = 16'h0000;
        glog_id.delete(); glog_cyc.delete();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        wait_res("t1_timeout");
        chk("t1_csum", res_csum, 16'hDCB9);
        chk("t1_ok", res_ok, 0);
        chk("t1_id", res_id, 0);
        if (glog_cyc.size() > 0) chk("t1_latency", cyc - glog_cyc[0], 3);
        drain();

        // Test 2: worst-case carry on requester 2
        randomize_data();
        req_sum[95:64]    = 32'hFFFF_FFFF;
        req_addend[47:32] = 16'hFFFF;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        wait_res("t2_timeout");
        chk("t2_csum", res_csum, 16'h0000);
        chk("t2_ok", res_ok, 1);
        chk("t2_id", res_id, 2);
        drain();

        // Test 3: all requesting after reset -> 0,1,2,3,0 every 3 cycles
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        randomize_data();
        glog_id.delete(); glog_cyc.delete();
        req_mask  = 4'hF;
        req_valid = 4'hF;
        wait_log(5, "t3_timeout");
        req_valid = '0;
        if (glog_id.size() >= 5) begin
            chk("t3_g0", glog_id[0], 0);
            chk("t3_g1", glog_id[1], 1);
            chk("t3_g2", glog_id[2], 2);
            chk("t3_g3", glog_id[3], 3);
            chk("t3_g4", glog_id[4], 0);
            for (int i = 1; i < 5; i++) chk("t3_spacing", glog_cyc[i] - glog_cyc[i-1], 3);
        end
        chk("t3_grant_count", grant_count, 5);
        drain();

        // Test 4: mask 1010 -> alternate 1,3
        randomize_data();
        glog_id.delete(); glog_cyc.delete();
        req_mask  = 4'b1010;
        req_valid = 4'hF;
        wait_log(4, "t4_timeout");
        req_valid = '0;
        if (glog_id.size() >= 4) begin
            chk("t4_g0", glog_id[0], 1);
            chk("t4_g1", glog_id[1], 3);
            chk("t4_g2", glog_id[2], 1);
            chk("t4_g3", glog_id[3], 3);
        end
        drain();

        // Test 5: back-pressure in OUT, then accept on release
        req_mask = 4'hF;
        randomize_data();
        glog_id.delete(); glog_cyc.delete();
        res_ready = 1'b0;
        req_valid = 4'b0010;
        wait_res("t5_timeout");
        h_csum = res_csum; h_id = res_id; h_ok = res_ok; h_cnt = grant_count;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_valid", res_valid, 1);
            chk("t5_hold_csum", res_csum, h_csum);
            chk("t5_hold_id", res_id, h_id);
            chk("t5_hold_ok", res_ok, h_ok);
            chk("t5_hold_ready", req_ready, 0);
            chk("t5_hold_count", grant_count, h_cnt);
        end
        res_ready = 1'b1;
        c0 = cyc;
        step();
        req_valid = '0;
        chk("t5_reaccept", glog_id.size(), 2);
        if (glog_cyc.size() >= 2) chk("t5_reaccept_cyc", glog_cyc[1], c0);
        wait_res("t5_next_timeout");
        chk("t5_next_latency", cyc - c0, 3);
        drain();

        // Test 6: reset during FOLD2
        randomize_data();
        glog_id.delete(); glog_cyc.delete();
        req_valid = 4'hF;
        wait_log(1, "t6_timeout");
        step();
        rst = 1'b1;
        step();
        chk("t6_res_valid", res_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant_count", grant_count, 0);
        rst = 1'b0;
        glog_id.delete(); glog_cyc.delete();
        wait_log(1, "t6_post_timeout");
        if (glog_id.size() >= 1) chk("t6_first_grant", glog_id[0], 0);
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            randomize_data();
            req_valid = N'($urandom);
            req_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
